// File: rtl/systolic_defs_pkg.sv
// Shared sizing helpers for the systolic result path: element count, index width
// and the bit offset of element (r,c) inside a flattened C matrix.
package systolic_defs;

    localparam int DEF_ROWS      = 2;
    localparam int DEF_COLS      = 2;
    localparam int DEF_ACC_WIDTH = 9;

    function automatic int num_elems(input int rows, input int cols);
        return rows * cols;
    endfunction

    // Index counters need at least one bit even for a 1x1 matrix.
    function automatic int idx_width(input int elems);
        return (elems <= 1) ? 1 : $clog2(elems);
    endfunction

    function automatic int elem_lsb(input int r, input int c, input int cols, input int acc_w);
        return (r * cols + c) * acc_w;
    endfunction

endpackage

// File: rtl/systolic_pingpong_buf.sv
// Two-slot ping-pong store for whole C matrices. Arbitrates capture against the
// slot release that happens on the final element handshake.
module systolic_pingpong_buf
    import systolic_defs::*;
#(
    parameter int FLAT_W = 36
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLAT_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              rd_free,
    output logic [FLAT_W-1:0] rd_data,
    output logic [1:0]        count,
    output logic              drop
);

    logic [FLAT_W-1:0] slot0;
    logic [FLAT_W-1:0] slot1;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              accept;

    // A full buffer can still take a matrix when the read slot frees on this edge;
    // in that case wr_ptr already points at the slot being released.
    assign accept  = wr_en && ((count != 2'd2) || rd_free);
    assign drop    = wr_en && !accept;
    assign rd_data = rd_ptr ? slot1 : slot0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0  <= '0;
            slot1  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (accept) begin
                if (wr_ptr) slot1 <= wr_data;
                else        slot0 <= wr_data;
                wr_ptr <= ~wr_ptr;
            end
            if (rd_free) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, rd_free})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/systolic_result_serializer.sv
// Captures each flattened C matrix from the systolic array and streams it
// row-major, one element per handshake, with row and matrix end flags.
module systolic_result_serializer
    import systolic_defs::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ROWS*COLS*ACC_WIDTH-1:0] c_in,
    input  logic                           c_valid,
    output logic [ACC_WIDTH-1:0]           m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           m_last_col,
    output logic                           m_last,
    output logic                           busy,
    output logic                           overflow,
    input  logic                           ovf_clear
);

    localparam int ELEMS  = num_elems(ROWS, COLS);
    localparam int IDX_W  = idx_width(ELEMS);
    localparam int FLAT_W = ELEMS * ACC_WIDTH;

    logic [IDX_W-1:0]  idx;
    logic [1:0]        count;
    logic [FLAT_W-1:0] rd_data;
    logic              drop;
    logic              fire;
    logic              at_end;
    logic              final_fire;

    assign m_valid    = (count != 2'd0);
    assign busy       = (count != 2'd0);
    assign fire       = m_valid && m_ready;
    assign at_end     = (idx == IDX_W'(ELEMS - 1));
    assign final_fire = fire && at_end;
    assign m_last     = m_valid && at_end;
    assign m_last_col = m_valid && ((int'(idx) % COLS) == (COLS - 1));

    systolic_pingpong_buf #(
        .FLAT_W (FLAT_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_data (c_in),
        .wr_en   (c_valid),
        .rd_free (final_fire),
        .rd_data (rd_data),
        .count   (count),
        .drop    (drop)
    );

    // Output mux reads only the registered slot, never c_in.
    always_comb begin
        m_data = '0;
        for (int e = 0; e < ELEMS; e++) begin
            if (idx == IDX_W'(e)) begin
                m_data = rd_data[elem_lsb(e / COLS, e % COLS, COLS, ACC_WIDTH) +: ACC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (fire) begin
            idx <= at_end ? '0 : idx + 1'b1;
        end
    end

    // A drop in the same cycle as a clear must stay visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

endmodule
